// File: rtl/sys2x2_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sys2x2_ctrl_if
//  Description : Bundle of job control, weight/vector streams, array drive
//                and result stream for the 2x2 systolic job sequencer.
//                The slave modport is the sequencer; master is its environment
//                (host/DMA plus the PE array).
//  Revision    : 1.0  initial release
// ============================================================================
interface sys2x2_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             busy;
  logic             done;
  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_data;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] arr_b00;
  logic [WIDTH-1:0] arr_b01;
  logic [WIDTH-1:0] arr_b10;
  logic [WIDTH-1:0] arr_b11;
  logic [WIDTH-1:0] arr_a0;
  logic [WIDTH-1:0] arr_a1;
  logic [WIDTH-1:0] arr_y0;
  logic [WIDTH-1:0] arr_y1;
  logic             y_valid;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;

  modport slave (
    input  start, num_vec, w_valid, w_data, x_valid, x0, x1, arr_y0, arr_y1,
    output busy, done, w_ready, x_ready,
    output arr_b00, arr_b01, arr_b10, arr_b11, arr_a0, arr_a1,
    output y_valid, y0, y1
  );

  modport master (
    output start, num_vec, w_valid, w_data, x_valid, x0, x1, arr_y0, arr_y1,
    input  busy, done, w_ready, x_ready,
    input  arr_b00, arr_b01, arr_b10, arr_b11, arr_a0, arr_a1,
    input  y_valid, y0, y1
  );
endinterface
`default_nettype wire

// File: rtl/sys2x2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sys2x2_ctrl
//  Description : Job sequencer for a 2x2 weight-stationary systolic array.
//                Loads four weights, injects vectors with a one-cycle row
//                skew, de-skews the two column results into one beat per
//                vector and pulses done when the job has fully drained.
//  Revision    : 1.0  initial release
// ============================================================================
module sys2x2_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sys2x2_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_q;
  logic [1:0]       wcnt_q;
  logic [WIDTH-1:0] b00_q, b01_q, b10_q, b11_q;
  logic [WIDTH-1:0] a0_q, a1_q, x1_dly_q;
  logic [4:0]       vpipe_q;   // bit k set: vector accepted k+1 edges ago
  logic [WIDTH-1:0] y0_cap_q, y0_q, y1_q;

  logic w_rdy, x_rdy, w_fire, x_fire, start_fire;

  assign w_fire     = w_rdy & bus.w_valid;
  assign x_fire     = x_rdy & bus.x_valid;
  assign start_fire = (state_q == S_IDLE) & bus.start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake readiness
  always_comb begin
    state_d = state_q;
    w_rdy   = 1'b0;
    x_rdy   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        w_rdy = 1'b1;
        if (bus.w_valid && (wcnt_q == 2'd3))
          state_d = (num_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        x_rdy = (acc_q < num_q);
        if (x_rdy && bus.x_valid && (acc_q == num_q - 1'b1))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Only the final output stage may still hold the last beat
        if (vpipe_q[3:0] == 4'd0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job length latch and accepted-vector counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      acc_q <= '0;
    end else if (start_fire) begin
      num_q <= bus.num_vec;
      acc_q <= '0;
    end else if (x_fire) begin
      acc_q <= acc_q + 1'b1;
    end
  end

  // Weight registers, written in order b00, b01, b10, b11
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= 2'd0;
      b00_q  <= '0;
      b01_q  <= '0;
      b10_q  <= '0;
      b11_q  <= '0;
    end else if (start_fire) begin
      wcnt_q <= 2'd0;
    end else if (w_fire) begin
      wcnt_q <= wcnt_q + 2'd1;
      case (wcnt_q)
        2'd0:    b00_q <= bus.w_data;
        2'd1:    b01_q <= bus.w_data;
        2'd2:    b10_q <= bus.w_data;
        default: b11_q <= bus.w_data;
      endcase
    end
  end

  // Row injection: row 1 trails row 0 by one cycle; idle cycles inject zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q     <= '0;
      x1_dly_q <= '0;
      a1_q     <= '0;
    end else begin
      a0_q     <= x_fire ? bus.x0 : '0;
      x1_dly_q <= x_fire ? bus.x1 : '0;
      a1_q     <= x1_dly_q;
    end
  end

  // De-skew: column 0 arrives one cycle before column 1, so hold it a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q  <= 5'd0;
      y0_cap_q <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
    end else begin
      vpipe_q <= {vpipe_q[3:0], x_fire};
      if (vpipe_q[2]) y0_cap_q <= bus.arr_y0;
      if (vpipe_q[3]) begin
        y0_q <= y0_cap_q;
        y1_q <= bus.arr_y1;
      end
    end
  end

  assign bus.busy    = (state_q == S_LOAD) | (state_q == S_RUN) | (state_q == S_DRAIN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.w_ready = w_rdy;
  assign bus.x_ready = x_rdy;
  assign bus.arr_b00 = b00_q;
  assign bus.arr_b01 = b01_q;
  assign bus.arr_b10 = b10_q;
  assign bus.arr_b11 = b11_q;
  assign bus.arr_a0  = a0_q;
  assign bus.arr_a1  = a1_q;
  assign bus.y_valid = vpipe_q[4];
  assign bus.y0      = y0_q;
  assign bus.y1      = y1_q;

endmodule
`default_nettype wire

// File: tb/tb_sys2x2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys2x2_ctrl
//  Description : Directed bench for sys2x2_ctrl driving a registered 2x2
//                Q5.10 PE array model; expected results are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sys2x2_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sys2x2_ctrl_if #(.WIDTH(16), .CNT_W(8)) bus ();

  sys2x2_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Registered PE array: a moves right, partial sums move down, one cycle each
  logic [15:0] a00_q, a10_q, y00_q, y01_q, y10_q, y11_q;

  function automatic logic [15:0] mac(input logic [15:0] y, input logic [15:0] a,
                                      input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return y + p[25:10];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a00_q <= '0; a10_q <= '0;
      y00_q <= '0; y01_q <= '0; y10_q <= '0; y11_q <= '0;
    end else begin
      a00_q <= bus.arr_a0;
      a10_q <= bus.arr_a1;
      y00_q <= mac(16'h0000, bus.arr_a0, bus.arr_b00);
      y01_q <= mac(16'h0000, a00_q,      bus.arr_b01);
      y10_q <= mac(y00_q,    bus.arr_a1, bus.arr_b10);
      y11_q <= mac(y01_q,    a10_q,      bus.arr_b11);
    end
  end
  assign bus.arr_y0 = y10_q;
  assign bus.arr_y1 = y11_q;

  // Stimulus and expected values
  logic [15:0] wv [4] = '{16'h0400, 16'h0800, 16'hFC00, 16'h0200};
  logic [15:0] vx0[3] = '{16'h0600, 16'h0000, 16'hF400};
  logic [15:0] vx1[3] = '{16'h0800, 16'h0000, 16'h0400};
  logic [15:0] ey0[3] = '{16'hFE00, 16'h0000, 16'hF000};
  logic [15:0] ey1[3] = '{16'h1000, 16'h0000, 16'hEA00};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc[4];
  logic [31:0] yq[$];
  int          ycq[$];

  // Output monitor, sampling 1 ns after each rising edge
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (bus.y_valid) begin
      yq.push_back({bus.y0, bus.y1});
      ycq.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    yq.delete();
    ycq.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int n);
    bus.start   = 1'b1;
    bus.num_vec = 8'(n);
    tick();
    bus.start   = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic load_weights();
    for (int i = 0; i < 4; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = wv[i];
      check($sformatf("w_ready_%0d", i), 32'(bus.w_ready), 32'd1);
      tick();
    end
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    check("arr_b00", 32'(bus.arr_b00), 32'(wv[0]));
    check("arr_b01", 32'(bus.arr_b01), 32'(wv[1]));
    check("arr_b10", 32'(bus.arr_b10), 32'(wv[2]));
    check("arr_b11", 32'(bus.arr_b11), 32'(wv[3]));
  endtask

  task automatic send_vecs(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.x_valid = 1'b1;
      bus.x0      = vx0[i];
      bus.x1      = vx1[i];
      check($sformatf("x_ready_%0d", i), 32'(bus.x_ready), 32'd1);
      tick();
      acc_cyc[i]  = cyc;
      bus.x_valid = 1'b0;
      bus.x0      = '0;
      bus.x1      = '0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && done_cnt == 0; k++) tick();
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_beats(input string tag, input int n);
    check({tag, "_beats"}, 32'(yq.size()), 32'(n));
    for (int i = 0; i < n && i < yq.size(); i++) begin
      check($sformatf("%s_y_%0d", tag, i), yq[i], {ey0[i], ey1[i]});
      check($sformatf("%s_ycyc_%0d", tag, i), 32'(ycq[i]), 32'(acc_cyc[i] + 4));
    end
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(acc_cyc[n-1] + 5));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy),    32'd0);
    check({tag, "_done"},  32'(bus.done),    32'd0);
    check({tag, "_wrdy"},  32'(bus.w_ready), 32'd0);
    check({tag, "_xrdy"},  32'(bus.x_ready), 32'd0);
    check({tag, "_yv"},    32'(bus.y_valid), 32'd0);
    check({tag, "_y"},     {bus.y0, bus.y1}, 32'd0);
    check({tag, "_a"},     {bus.arr_a0, bus.arr_a1}, 32'd0);
    check({tag, "_b0x"},   {bus.arr_b00, bus.arr_b01}, 32'd0);
    check({tag, "_b1x"},   {bus.arr_b10, bus.arr_b11}, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.num_vec = '0;
    bus.w_valid = 1'b0; bus.w_data = '0;
    bus.x_valid = 1'b0; bus.x0 = '0; bus.x1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single vector: skew, latency, values, done
    clear_mon();
    do_start(1);
    load_weights();
    send_vecs(1, 0);
    check("single_a0", 32'(bus.arr_a0), 32'h0600);
    check("single_a1_early", 32'(bus.arr_a1), 32'h0);
    check("single_xrdy_drain", 32'(bus.x_ready), 32'd0);
    tick();
    check("single_a1", 32'(bus.arr_a1), 32'h0800);
    check("single_a0_bubble", 32'(bus.arr_a0), 32'h0);
    wait_done();
    check("single_busy_at_done", 32'(bus.busy), 32'd0);
    check_beats("single", 1);
    tick();

    // Burst of three
    clear_mon();
    do_start(3);
    load_weights();
    send_vecs(3, 0);
    wait_done();
    check_beats("burst", 3);
    tick();

    // Same vectors with one-cycle bubbles
    clear_mon();
    do_start(3);
    load_weights();
    send_vecs(3, 1);
    wait_done();
    check_beats("bubble", 3);
    tick();

    // Zero-length job
    clear_mon();
    do_start(0);
    load_weights();
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    tick();
    check("zero_beats", 32'(yq.size()), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'd1);

    // Start while busy is ignored
    clear_mon();
    do_start(2);
    load_weights();
    bus.start = 1'b1; bus.num_vec = 8'd5;
    send_vecs(2, 0);
    bus.start = 1'b0; bus.num_vec = '0;
    wait_done();
    check_beats("busy_start", 2);
    repeat (2) tick();
    check("busy_start_idle_wrdy", 32'(bus.w_ready), 32'd0);
    check("busy_start_idle_busy", 32'(bus.busy), 32'd0);

    // Reset mid-RUN after 2 of 4 vectors
    clear_mon();
    do_start(4);
    load_weights();
    send_vecs(2, 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("midrst_no_y", 32'(yq.size()), 32'd0);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_idle", 32'(bus.busy), 32'd0);

    // Fresh job after reset
    clear_mon();
    do_start(1);
    load_weights();
    send_vecs(1, 0);
    wait_done();
    check_beats("fresh", 1);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
